// File: rtl/load_writeback_unit_pkg.sv
// Shared definitions for the load/writeback unit: funct3 encodings,
// the controller state enum and the alignment helper.
package load_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } load_state_t;

  // True when the low address bits are not a multiple of the access size.
  // Byte loads are never misaligned; the illegal funct3 is handled separately.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr);
    logic result;
    case (funct3)
      LH, LHU: result = (addr[0] != 1'b0);
      LW, LWU: result = (addr[1:0] != 2'b00);
      LD:      result = (addr != 3'b000);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_writeback_unit_extender.sv
// Selects the addressed byte lane of a little-endian doubleword and
// sign- or zero-extends it according to the load type.
module load_extender
  import load_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  addr,
  input  logic [2:0]  funct3,
  output logic [63:0] extended
);

  logic [63:0] shifted;

  // Move the addressed lane down to bit 0, then extend to full width.
  always_comb begin
    shifted  = dword >> {addr, 3'b000};
    extended = shifted;
    case (funct3)
      LB:      extended = {{56{shifted[7]}}, shifted[7:0]};
      LH:      extended = {{48{shifted[15]}}, shifted[15:0]};
      LW:      extended = {{32{shifted[31]}}, shifted[31:0]};
      LD:      extended = shifted;
      LBU:     extended = {56'd0, shifted[7:0]};
      LHU:     extended = {48'd0, shifted[15:0]};
      LWU:     extended = {32'd0, shifted[31:0]};
      default: extended = shifted;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle RV64 load unit: accepts a decoded load, issues a doubleword
// memory read, extracts/extends the result and writes the register file.
module load_writeback_unit
  import load_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_address,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_address,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            reg_write,
  output logic [4:0]      rd_address,
  output logic [XLEN-1:0] write_data,
  output logic            load_error
);

  load_state_t     state;
  load_state_t     next_state;
  logic [XLEN-1:0] latched_address;
  logic [2:0]      latched_funct3;
  logic [4:0]      latched_rd;
  logic [XLEN-1:0] extended;
  logic            request_bad;

  // A request is rejected up front so it never reaches memory.
  assign request_bad = is_misaligned(req_funct3, req_address[2:0]) || (req_funct3 == 3'b111);

  // The memory only ever sees doubleword-aligned addresses.
  assign mem_req_address = {latched_address[XLEN-1:3], 3'b000};

  load_extender extender (
    .dword    (mem_resp_data),
    .addr     (latched_address[2:0]),
    .funct3   (latched_funct3),
    .extended (extended)
  );

  // Controller state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and handshake/write-enable outputs.
  always_comb begin
    next_state    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    reg_write     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !request_bad) next_state = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) next_state = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) next_state = WRITE;
      end
      WRITE: begin
        reg_write  = (latched_rd != 5'd0);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, error pulse and registered writeback result; the
  // writeback address/data only change when a response is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latched_address <= '0;
      latched_funct3  <= 3'b000;
      latched_rd      <= 5'd0;
      rd_address      <= 5'd0;
      write_data      <= '0;
      load_error      <= 1'b0;
    end else begin
      load_error <= 1'b0;
      if (state == IDLE && req_valid) begin
        latched_address <= req_address;
        latched_funct3  <= req_funct3;
        latched_rd      <= req_rd;
        load_error      <= request_bad;
      end
      if (state == WAIT && mem_resp_valid) begin
        write_data <= extended;
        rd_address <= latched_rd;
      end
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: directed loads followed by
// randomized loads compared against a byte-level reference model.
module tb_load_writeback_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_address;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_address;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        reg_write;
  logic [4:0]  rd_address;
  logic [63:0] write_data;
  logic        load_error;

  int checkCount = 0;
  int errorCount = 0;

  load_writeback_unit #(.XLEN(64)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_address     (req_address),
    .req_funct3      (req_funct3),
    .req_rd          (req_rd),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_address (mem_req_address),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .reg_write       (reg_write),
    .rd_address      (rd_address),
    .write_data      (write_data),
    .load_error      (load_error)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: access size in bytes is 2**funct3[1:0]; funct3 7 is illegal.
  function automatic logic refBad(input logic [63:0] addr, input logic [2:0] f3);
    int size;
    if (f3 == 3'b111) return 1'b1;
    size = 1 << f3[1:0];
    return (int'(addr[2:0]) % size) != 0;
  endfunction

  // Reference: gather bytes little-endian from the addressed offset, then
  // fill the upper bits with the top bit for signed loads.
  function automatic logic [63:0] refLoad(input logic [63:0] data, input logic [2:0] addr3, input logic [2:0] f3);
    logic [7:0]  bytes [8];
    logic [63:0] value;
    int size;
    size  = 1 << f3[1:0];
    value = 64'd0;
    for (int i = 0; i < 8; i++) bytes[i] = data[8*i +: 8];
    for (int i = 0; i < size; i++) value = value | (64'(bytes[int'(addr3) + i]) << (8 * i));
    if (!f3[2] && size < 8 && value[8*size-1]) value = value | (~64'd0 << (8 * size));
    return value;
  endfunction

  // Drives one load through the unit with the given memory delays and
  // checks every cycle of its handshake and writeback.
  task automatic applyStimulus(input logic [63:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                               input logic [63:0] data, input int readyDelay, input int respDelay);
    logic        bad;
    logic [63:0] expected;
    bad      = refBad(addr, f3);
    expected = refLoad(data, addr[2:0], f3);
    @(negedge clock);
    checkOutput("req_ready before accept", {63'd0, req_ready}, 64'd1);
    req_valid   = 1'b1;
    req_address = addr;
    req_funct3  = f3;
    req_rd      = rd;
    @(negedge clock);
    req_valid = 1'b0;
    if (bad) begin
      checkOutput("load_error pulse", {63'd0, load_error}, 64'd1);
      checkOutput("no mem_req_valid on error", {63'd0, mem_req_valid}, 64'd0);
      checkOutput("req_ready after error", {63'd0, req_ready}, 64'd1);
      checkOutput("no reg_write on error", {63'd0, reg_write}, 64'd0);
      return;
    end
    checkOutput("load_error quiet", {63'd0, load_error}, 64'd0);
    for (int i = 0; i < readyDelay; i++) begin
      checkOutput("mem_req_valid held", {63'd0, mem_req_valid}, 64'd1);
      checkOutput("mem_req_address held", mem_req_address, {addr[63:3], 3'b000});
      checkOutput("req_ready low in REQ", {63'd0, req_ready}, 64'd0);
      @(negedge clock);
    end
    checkOutput("mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    checkOutput("mem_req_address", mem_req_address, {addr[63:3], 3'b000});
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = ~data;
    @(negedge clock);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    checkOutput("mem_req_valid drops", {63'd0, mem_req_valid}, 64'd0);
    for (int i = 0; i < respDelay; i++) begin
      checkOutput("no reg_write in WAIT", {63'd0, reg_write}, 64'd0);
      checkOutput("req_ready low in WAIT", {63'd0, req_ready}, 64'd0);
      @(negedge clock);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    mem_resp_data  = {$urandom, $urandom};
    checkOutput("reg_write", {63'd0, reg_write}, {63'd0, rd != 5'd0});
    checkOutput("rd_address", {59'd0, rd_address}, {59'd0, rd});
    checkOutput("write_data", write_data, expected);
    checkOutput("req_ready low in WRITE", {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    checkOutput("reg_write single pulse", {63'd0, reg_write}, 64'd0);
    checkOutput("req_ready back", {63'd0, req_ready}, 64'd1);
    checkOutput("write_data held", write_data, expected);
  endtask

  // Directed scenarios followed by a randomized sweep.
  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_address    = 64'd0;
    req_funct3     = 3'd0;
    req_rd         = 5'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 64'd0;
    repeat (2) @(negedge clock);
    checkOutput("reset req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("reset mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("reset mem_req_address", mem_req_address, 64'd0);
    checkOutput("reset reg_write", {63'd0, reg_write}, 64'd0);
    checkOutput("reset rd_address", {59'd0, rd_address}, 64'd0);
    checkOutput("reset write_data", write_data, 64'd0);
    checkOutput("reset load_error", {63'd0, load_error}, 64'd0);
    reset = 1'b0;

    applyStimulus(64'h1003, 3'b000, 5'd7, 64'h0000_0000_80FF_0000, 0, 0);
    checkOutput("LB constant", write_data, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(64'h2004, 3'b110, 5'd3, 64'h8765_4321_0000_0000, 0, 0);
    checkOutput("LWU constant", write_data, 64'h0000_0000_8765_4321);
    applyStimulus(64'h2004, 3'b010, 5'd4, 64'h8765_4321_0000_0000, 1, 1);
    checkOutput("LW constant", write_data, 64'hFFFF_FFFF_8765_4321);
    applyStimulus(64'h3000, 3'b011, 5'd10, 64'hDEAD_BEEF_0123_4567, 3, 2);
    checkOutput("LD constant", write_data, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(64'h4001, 3'b001, 5'd5, 64'h0, 0, 0);
    applyStimulus(64'h4000, 3'b111, 5'd5, 64'h0, 0, 0);
    applyStimulus(64'h5000, 3'b010, 5'd0, 64'h1234_5678_9ABC_DEF0, 0, 1);

    // Reset while waiting for a response, then a stray response.
    @(negedge clock);
    req_valid   = 1'b1;
    req_address = 64'h7000;
    req_funct3  = 3'b011;
    req_rd      = 5'd9;
    @(negedge clock);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    checkOutput("in WAIT before reset", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid reset req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("mid reset write_data", write_data, 64'd0);
    checkOutput("mid reset mem_req_address", mem_req_address, 64'd0);
    @(negedge clock);
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    checkOutput("stray resp no reg_write", {63'd0, reg_write}, 64'd0);
    checkOutput("stray resp req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clock);
    checkOutput("stray resp no reg_write later", {63'd0, reg_write}, 64'd0);
    applyStimulus(64'h6007, 3'b100, 5'd12, 64'hAB00_0000_0000_0000, 0, 0);
    checkOutput("LBU constant", write_data, 64'h0000_0000_0000_00AB);

    for (int n = 0; n < 60; n++) begin
      applyStimulus({$urandom, $urandom}, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
